// File: rtl/uart_alu_ctrl_if.sv
// UART <-> ALU controller bus: receiver/transmitter handshakes plus the
// registered operand/result signals exchanged with the external ALU.
interface uart_alu_ctrl_if #(
   parameter int N = 8
);
   logic         rx_done_tick;
   logic [N-1:0] rx_data;
   logic [N-1:0] alu_result;
   logic         tx_done_tick;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [N-1:0] alu_op;
   logic         tx_start;
   logic [N-1:0] tx_data;
   logic         err_ovr;
   logic         err_tmo;

   modport slave (
      input  rx_done_tick, rx_data, alu_result, tx_done_tick,
      output alu_a, alu_b, alu_op, tx_start, tx_data, err_ovr, err_tmo
   );

   modport master (
      output rx_done_tick, rx_data, alu_result, tx_done_tick,
      input  alu_a, alu_b, alu_op, tx_start, tx_data, err_ovr, err_tmo
   );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Collects an A/B/OP byte frame from a UART receiver, drives the ALU operands,
// captures the result and hands it to the UART transmitter.
module uart_alu_ctrl #(
   parameter int N       = 8,
   parameter int TIMEOUT = 100000
) (
   input  logic           clk,
   input  logic           reset,
   uart_alu_ctrl_if.slave bus
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_A, S_B, S_OP, S_CALC, S_SEND, S_WAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  a_q, b_q, op_q, tx_q;
   logic          tx_start_q, err_ovr_q, err_tmo_q;
   logic          ld_a, ld_b, ld_op, ld_tx, start_d, ovr_d, tmo_d, cnt_inc, expired;

   assign expired = (cnt_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      ld_op   = 1'b0;
      ld_tx   = 1'b0;
      start_d = 1'b0;
      ovr_d   = 1'b0;
      tmo_d   = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         S_A: if (bus.rx_done_tick) begin
            ld_a    = 1'b1;
            state_d = S_B;
         end
         S_B: if (bus.rx_done_tick) begin
            ld_b    = 1'b1;
            state_d = S_OP;
         end else if (expired) begin
            tmo_d   = 1'b1;
            state_d = S_A;
         end else cnt_inc = 1'b1;
         S_OP: if (bus.rx_done_tick) begin
            ld_op   = 1'b1;
            state_d = S_CALC;
         end else if (expired) begin
            tmo_d   = 1'b1;
            state_d = S_A;
         end else cnt_inc = 1'b1;
         // tx_start is registered here so it is high exactly while in S_SEND
         S_CALC: begin
            ovr_d   = bus.rx_done_tick;
            ld_tx   = 1'b1;
            start_d = 1'b1;
            state_d = S_SEND;
         end
         S_SEND: begin
            ovr_d   = bus.rx_done_tick;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            ovr_d = bus.rx_done_tick;
            if (bus.tx_done_tick) state_d = S_A;
         end
         default: state_d = S_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_A;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         tx_q       <= '0;
         tx_start_q <= 1'b0;
         err_ovr_q  <= 1'b0;
         err_tmo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         // every accepted byte changes state, so a state change covers both clears
         if (state_d != state_q) cnt_q <= '0;
         else if (cnt_inc)       cnt_q <= cnt_q + 1'b1;
         if (ld_a)  a_q  <= bus.rx_data;
         if (ld_b)  b_q  <= bus.rx_data;
         if (ld_op) op_q <= bus.rx_data;
         if (ld_tx) tx_q <= bus.alu_result;
         tx_start_q <= start_d;
         err_ovr_q  <= ovr_d;
         err_tmo_q  <= tmo_d;
      end
   end

   assign bus.alu_a    = a_q;
   assign bus.alu_b    = b_q;
   assign bus.alu_op   = op_q;
   assign bus.tx_data  = tx_q;
   assign bus.tx_start = tx_start_q;
   assign bus.err_ovr  = err_ovr_q;
   assign bus.err_tmo  = err_tmo_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed vector table, timeout sequences and a
// randomized run against a frame-level reference model.
module tb_uart_alu_ctrl;
   localparam int TMO = 16;

   logic clk;
   logic reset;
   int   errs  = 0;
   int   n_chk = 0;

   uart_alu_ctrl_if #(.N(8)) bus ();

   uart_alu_ctrl #(.N(8), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      case (op)
         8'h20:   return a + b;
         8'h22:   return a - b;
         8'h24:   return a & b;
         8'h25:   return a | b;
         8'h26:   return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, rxt, txt;
      logic [7:0] rxd;
      logic [7:0] a, b, op, tx;
      logic       txs, ovr, tmo;
   } vec_t;

   function automatic vec_t v(input int rst, input int rxt, input int rxd, input int txt,
                              input int a, input int b, input int op, input int tx,
                              input int txs, input int ovr, input int tmo);
      vec_t r;
      r.rst = rst[0]; r.rxt = rxt[0]; r.rxd = rxd[7:0]; r.txt = txt[0];
      r.a = a[7:0]; r.b = b[7:0]; r.op = op[7:0]; r.tx = tx[7:0];
      r.txs = txs[0]; r.ovr = ovr[0]; r.tmo = tmo[0];
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rt, input logic [7:0] d, input logic tt);
      reset            = r;
      bus.rx_done_tick = rt;
      bus.rx_data      = d;
      bus.tx_done_tick = tt;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] tx,
                          input logic txs, input logic ovr, input logic tmo);
      chk({tag, " alu_a"},    bus.alu_a,    a);
      chk({tag, " alu_b"},    bus.alu_b,    b);
      chk({tag, " alu_op"},   bus.alu_op,   op);
      chk({tag, " tx_data"},  bus.tx_data,  tx);
      chk({tag, " tx_start"}, bus.tx_start, txs);
      chk({tag, " err_ovr"},  bus.err_ovr,  ovr);
      chk({tag, " err_tmo"},  bus.err_tmo,  tmo);
   endtask

   // Frame-level reference: bytes collected so far, cycles since the OP byte,
   // and idle cycles since the last accepted byte.
   logic [7:0] m_a, m_b, m_op, m_tx;
   logic       m_txs, m_ovr, m_tmo;
   int         m_got, m_post, m_idle;

   task automatic model_step(input logic r, input logic rt, input logic [7:0] d, input logic tt);
      m_txs = 0; m_ovr = 0; m_tmo = 0;
      if (r) begin
         m_a = 0; m_b = 0; m_op = 0; m_tx = 0;
         m_got = 0; m_post = 0; m_idle = 0;
      end else if (m_post != 0) begin
         m_ovr = rt;
         if (m_post == 1) begin
            m_tx = alu_fn(m_a, m_b, m_op); m_txs = 1; m_post = 2;
         end else if (m_post == 2) m_post = 3;
         else if (tt) m_post = 0;
      end else if (rt) begin
         case (m_got)
            0:       m_a  = d;
            1:       m_b  = d;
            default: m_op = d;
         endcase
         m_idle = 0;
         m_got++;
         if (m_got == 3) begin m_got = 0; m_post = 1; end
      end else if (m_got != 0) begin
         if (m_idle == TMO - 1) begin m_tmo = 1; m_got = 0; m_idle = 0; end
         else m_idle++;
      end
   endtask

   vec_t tbl[19];

   initial begin
      int k, pulses, dens;
      logic r, rt, tt;
      logic [7:0] d;

      //          rst rxt rxd  txt   a     b     op    tx   txs ovr tmo
      tbl[0]  = v(1, 0, 0,    0,  0,    0,    0,    0,    0, 0, 0);
      tbl[1]  = v(0, 1, 'h05, 0,  'h05, 0,    0,    0,    0, 0, 0);
      tbl[2]  = v(0, 0, 0,    1,  'h05, 0,    0,    0,    0, 0, 0);
      tbl[3]  = v(0, 1, 'h03, 0,  'h05, 'h03, 0,    0,    0, 0, 0);
      tbl[4]  = v(0, 1, 'h20, 0,  'h05, 'h03, 'h20, 0,    0, 0, 0);
      tbl[5]  = v(0, 0, 0,    0,  'h05, 'h03, 'h20, 'h08, 1, 0, 0);
      tbl[6]  = v(0, 0, 0,    0,  'h05, 'h03, 'h20, 'h08, 0, 0, 0);
      tbl[7]  = v(0, 1, 'h44, 0,  'h05, 'h03, 'h20, 'h08, 0, 1, 0);
      tbl[8]  = v(0, 0, 0,    0,  'h05, 'h03, 'h20, 'h08, 0, 0, 0);
      tbl[9]  = v(0, 0, 0,    1,  'h05, 'h03, 'h20, 'h08, 0, 0, 0);
      tbl[10] = v(0, 0, 0,    0,  'h05, 'h03, 'h20, 'h08, 0, 0, 0);
      tbl[11] = v(0, 1, 'h0A, 0,  'h0A, 'h03, 'h20, 'h08, 0, 0, 0);
      tbl[12] = v(0, 1, 'h04, 0,  'h0A, 'h04, 'h20, 'h08, 0, 0, 0);
      tbl[13] = v(0, 1, 'h22, 0,  'h0A, 'h04, 'h22, 'h08, 0, 0, 0);
      tbl[14] = v(0, 0, 0,    0,  'h0A, 'h04, 'h22, 'h06, 1, 0, 0);
      tbl[15] = v(1, 1, 'h99, 1,  0,    0,    0,    0,    0, 0, 0);
      tbl[16] = v(0, 0, 0,    1,  0,    0,    0,    0,    0, 0, 0);
      tbl[17] = v(0, 0, 0,    0,  0,    0,    0,    0,    0, 0, 0);
      tbl[18] = v(0, 1, 'h07, 0,  'h07, 0,    0,    0,    0, 0, 0);

      drive(1, 0, 0, 0);
      step();
      for (int i = 0; i < 19; i++) begin
         drive(tbl[i].rst, tbl[i].rxt, tbl[i].rxd, tbl[i].txt);
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tx,
                 tbl[i].txs, tbl[i].ovr, tbl[i].tmo);
      end

      // Timeout: A byte then silence; err_tmo must appear once, 16 cycles after S_B entry
      drive(1, 0, 0, 0); step();
      drive(0, 1, 8'h11, 0); step();
      k = 0; pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         drive(0, 0, 0, 0); step();
         if (bus.err_tmo) begin
            pulses++;
            if (k == 0) k = i;
         end
      end
      chk("tmo_cycle", k, 16);
      chk("tmo_pulses", pulses, 1);
      chk("tmo_alu_a", bus.alu_a, 8'h11);
      drive(0, 1, 8'h33, 0); step();
      chk("tmo_back_in_S_A a", bus.alu_a, 8'h33);
      chk("tmo_back_in_S_A b", bus.alu_b, 8'h00);

      // Boundary: second byte lands exactly in the expiry cycle
      drive(1, 0, 0, 0); step();
      drive(0, 1, 8'h11, 0); step();
      for (int i = 0; i < TMO - 1; i++) begin
         drive(0, 0, 0, 0); step();
      end
      drive(0, 1, 8'h22, 0); step();
      chk("bnd_alu_b", bus.alu_b, 8'h22);
      chk("bnd_err_tmo", bus.err_tmo, 1'b0);
      drive(0, 1, 8'h20, 0); step();
      chk("bnd_alu_op", bus.alu_op, 8'h20);
      drive(0, 0, 0, 0); step();
      chk("bnd_tx_start", bus.tx_start, 1'b1);
      chk("bnd_tx_data", bus.tx_data, 8'h33);

      // Randomized run against the reference model with varying tick density
      drive(1, 0, 0, 0); step();
      model_step(1, 0, 0, 0);
      dens = 30;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) dens = (i / 200) % 3 == 0 ? 3 : ((i / 200) % 3 == 1 ? 30 : 70);
         r  = ($urandom_range(0, 199) == 0);
         rt = ($urandom_range(0, 99) < dens);
         d  = 8'($urandom);
         tt = ($urandom_range(0, 7) == 0);
         drive(r, rt, d, tt);
         step();
         model_step(r, rt, d, tt);
         chk_all($sformatf("rnd%0d", i), m_a, m_b, m_op, m_tx, m_txs, m_ovr, m_tmo);
      end

      $display("Result: errors=%0d of %0d checks", errs, n_chk);
      $finish;
   end
endmodule
